// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side master for a 1-cycle-latency synchronous FIFO.
// Pops exactly xfer_len words after a start command and presents them on a
// valid/ready stream through a 2-entry skid buffer. The head entry of the skid
// is the registered m_data/m_valid output; a spare entry absorbs the word that
// is still in flight from the FIFO when the consumer stalls.
//
// Optional build macro FIFO_STARVE_TIMEOUT_EN: aborts a transfer after
// TIMEOUT_CYC consecutive starved cycles, drains what is already buffered and
// reports done with err=1. Without the macro err is constant 0.
//
// state | meaning
// IDLE  | waiting for start; done/busy tail of the previous transfer
// RUN   | issuing FIFO pops until issued == len (or starvation timeout)
// DRAIN | no more pops; emptying skid and in-flight word, then done
module fifo_stream_reader #(
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 11,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  xfer_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  xfer_count,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issued;
  logic               inflight;
  logic               spare_valid;
  logic [DATA_W-1:0]  spare_data;
  logic               pop;
  logic               push;
  logic [1:0]         occ;
  logic [1:0]         pend;
  logic               drain_empty;
  logic               timed_out;

`ifdef FIFO_STARVE_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  logic [SW-1:0]      starve_left;
`else
  assign timed_out = 1'b0;
`endif

  assign pop  = m_valid && m_ready;
  assign push = inflight;
  assign occ  = {1'b0, m_valid} + {1'b0, spare_valid};
  assign pend = occ + {1'b0, inflight};

  // Nothing left anywhere once this cycle's handshake (if any) completes.
  assign drain_empty = !inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop));

  // Pop only when the skid is guaranteed to have room for the returning word;
  // a handshake this cycle frees one slot, hence the combinational m_ready path.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (state == RUN)
      fifo_rd_en = !fifo_empty && (issued != len_q) && ((pend < 2'd2) || pop);
  end

  // Transfer sequencing, counters and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      xfer_count <= '0;
      len_q      <= '0;
      issued     <= '0;
`ifdef FIFO_STARVE_TIMEOUT_EN
      timed_out   <= 1'b0;
      starve_left <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (pop)
        xfer_count <= xfer_count + 1'b1;
      case (state)
        IDLE: begin
          // busy is still high on the done cycle, which blocks a start there
          if (start && !busy) begin
            busy       <= 1'b1;
            err        <= 1'b0;
            xfer_count <= '0;
            issued     <= '0;
            len_q      <= xfer_len;
`ifdef FIFO_STARVE_TIMEOUT_EN
            timed_out   <= 1'b0;
            starve_left <= SW'(TIMEOUT_CYC);
`endif
            if (xfer_len == '0)
              done <= 1'b1;
            else
              state <= RUN;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          if (fifo_rd_en) begin
            issued <= issued + 1'b1;
            if ((issued + 1'b1) == len_q)
              state <= DRAIN;
          end
`ifdef FIFO_STARVE_TIMEOUT_EN
          if (fifo_rd_en) begin
            starve_left <= SW'(TIMEOUT_CYC);
          end else if (fifo_empty) begin
            if (starve_left == SW'(1)) begin
              timed_out <= 1'b1;
              state     <= DRAIN;
            end else begin
              starve_left <= starve_left - 1'b1;
            end
          end
`endif
        end
        DRAIN: begin
          if (drain_empty) begin
            done  <= 1'b1;
            err   <= timed_out;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skid buffer: head is the stream output register, spare holds the overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight    <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      spare_valid <= 1'b0;
      spare_data  <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) begin
        if (spare_valid) begin
          m_data  <= spare_data;
          m_valid <= 1'b1;
          if (push) begin
            spare_data  <= fifo_rd_data;
            spare_valid <= 1'b1;
          end else begin
            spare_valid <= 1'b0;
          end
        end else begin
          m_valid <= push;
          if (push)
            m_data <= fifo_rd_data;
        end
      end else if (!m_valid) begin
        m_valid <= push;
        if (push)
          m_data <= fifo_rd_data;
      end else if (push) begin
        spare_data  <= fifo_rd_data;
        spare_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a behavioural FIFO and a
// word-order reference model.
module tb_fifo_stream_reader;
  localparam int DW = 32;
  localparam int LW = 11;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] xfer_len = '0;
  logic          busy, done, err;
  logic [LW-1:0] xfer_count;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_W(DW), .LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .xfer_len(xfer_len),
    .busy(busy), .done(done), .err(err), .xfer_count(xfer_count),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  int            done_cnt_q[$];
  bit            done_err_q[$];

  int  done_cnt = 0;
  int  exp_done = 0;
  int  rd_total = 0;
  int  cyc = 0;
  int  hs_first = -1;
  int  hs_last = -1;
  int  outstanding = 0;
  bit  stall_prev = 0;
  logic [DW-1:0] prev_data = '0;
  logic rd_s = 1'b0;
  int  ready_mode = 0;
  int  rdy_phase = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural FIFO: 1-cycle read latency, registered empty flag.
  always @(negedge clk) rd_s <= fifo_rd_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q.delete();
      wr_q.delete();
      fifo_rd_data <= '0;
      fifo_empty   <= 1'b1;
    end else begin
      if (rd_s) begin
        if (fifo_q.size() == 0) begin
          errors++;
          $display("FAIL fifo_underflow actual=pop_on_empty expected=no_pop");
        end else begin
          fifo_rd_data <= fifo_q.pop_front();
        end
      end
      while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Downstream ready pattern generator.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: begin
        m_ready = ((rdy_phase % 4) == 0) || ((rdy_phase % 4) == 3);
        rdy_phase++;
      end
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: stream order, stall stability, skid room rule, done status.
  always @(negedge clk) begin
    bit hs;
    cyc++;
    if (!rst_n) begin
      outstanding = 0;
      stall_prev = 0;
    end else begin
      hs = m_valid && m_ready;
      if (stall_prev)
        chk("hold_on_stall", {m_valid, m_data}, {1'b1, prev_data});
      if (hs) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word actual=%0h expected=none", m_data);
        end else begin
          chk("m_data", m_data, exp_q.pop_front());
        end
        if (hs_first < 0) hs_first = cyc;
        hs_last = cyc;
      end
      if (fifo_rd_en) begin
        rd_total++;
        chk("rd_en_room", (outstanding < 2) || hs, 1);
      end
      if (done) begin
        done_cnt++;
        if (done_cnt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          chk("xfer_count", xfer_count, done_cnt_q.pop_front());
          chk("err", err, done_err_q.pop_front());
          chk("busy_on_done", busy, 1);
        end
      end
      outstanding = outstanding + (fifo_rd_en ? 1 : 0) - (hs ? 1 : 0);
      stall_prev = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic fifo_write(input logic [DW-1:0] w);
    wr_q.push_back(w);
    model_q.push_back(w);
  endtask

  // The stream must carry the next len words that enter the FIFO; with a
  // starvation abort only the words the FIFO can supply come out.
  task automatic do_start(input int len, input bit starve);
    int n;
    n = len;
    if (starve && model_q.size() < len) n = model_q.size();
    for (int i = 0; i < n; i++) exp_q.push_back(model_q.pop_front());
    done_cnt_q.push_back(n);
    done_err_q.push_back(n < len);
    exp_done++;
    @(posedge clk); #1;
    start = 1'b1;
    xfer_len = LW'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done_cnt < exp_done && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (done_cnt < exp_done) begin
      errors++;
      $display("FAIL done_timeout actual=%0d expected=%0d", done_cnt, exp_done);
    end
  endtask

  initial begin
    int n;
    int rd0;
    int len;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_count", xfer_count, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    rst_n = 1'b1;

    // Full-rate transfer of 0..9
    ready_mode = 0;
    for (int i = 0; i < 10; i++) fifo_write(DW'(i));
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    hs_first = -1;
    do_start(10, 0);
    chk("busy_after_start", busy, 1);
    n = 0;
    while (n < 10) begin
      @(posedge clk); #1;
      n++;
      if (m_valid) break;
    end
    chk("first_valid_latency", n, 2);
    wait_done(100);
    chk("back_to_back", hs_last - hs_first, 9);
    repeat (5) @(posedge clk);
    #1;
    chk("single_done", done_cnt, exp_done);
    chk("busy_after_done", busy, 0);

    // Backpressure pattern 1,0,0,1
    rdy_phase = 0;
    ready_mode = 1;
    for (int i = 0; i < 10; i++) fifo_write(DW'(i));
    repeat (2) @(posedge clk);
    do_start(10, 0);
    wait_done(200);

    // Partial transfer, start while busy ignored
    ready_mode = 0;
    for (int i = 10; i < 20; i++) fifo_write(DW'(i));
    repeat (2) @(posedge clk);
    do_start(4, 0);
    @(posedge clk); #1;
    chk("busy_mid", busy, 1);
    start = 1'b1;
    xfer_len = LW'(7);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    repeat (20) @(posedge clk);
    #1;
    chk("ignored_start_no_done", done_cnt, exp_done);
    chk("fifo_left_size", fifo_q.size(), 6);
    chk("fifo_left_head", fifo_q[0], 14);
    ready_mode = 2;
    do_start(6, 0);
    wait_done(200);

    // Zero-length transfer
    ready_mode = 0;
    repeat (3) @(posedge clk);
    rd0 = rd_total;
    do_start(0, 0);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 1);
    wait_done(10);
    @(posedge clk); #1;
    chk("len0_done_pulse", done, 0);
    chk("len0_no_reads", rd_total, rd0);

    // Empty FIFO stall, words arrive 50 cycles later
    for (int i = 0; i < 3; i++) model_q.push_back(DW'(32'hA0 + i));
    rd0 = rd_total;
    do_start(3, 0);
    repeat (50) @(posedge clk);
    #1;
    chk("stall_busy", busy, 1);
    chk("stall_valid", m_valid, 0);
    chk("stall_no_reads", rd_total, rd0);
    for (int i = 0; i < 3; i++) wr_q.push_back(DW'(32'hA0 + i));
    wait_done(100);

    // Randomised transfers
    for (int t = 0; t < 6; t++) begin
      ready_mode = 2;
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) fifo_write($urandom);
      do_start(len, 0);
      wait_done(2000);
    end

    // Reset in the middle of a long transfer
    for (int i = 0; i < 1024; i++) fifo_write($urandom);
    do_start(1024, 0);
    repeat (100) @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    done_cnt_q.delete();
    done_err_q.delete();
    model_q.delete();
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_count", xfer_count, 0);
    chk("arst_rd_en", fifo_rd_en, 0);
    chk("arst_valid", m_valid, 0);
    chk("arst_data", m_data, 0);
    exp_done = done_cnt;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    ready_mode = 0;
    for (int i = 0; i < 5; i++) fifo_write(DW'(32'h500 + i));
    repeat (2) @(posedge clk);
    do_start(5, 0);
    wait_done(100);

`ifdef FIFO_STARVE_TIMEOUT_EN
    // Starvation abort: 8 requested, 5 available
    ready_mode = 0;
    for (int i = 0; i < 5; i++) fifo_write(DW'(32'h700 + i));
    repeat (2) @(posedge clk);
    do_start(8, 1);
    wait_done(200);
`endif

    repeat (5) @(posedge clk);
    chk("all_words_seen", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
